// File: rtl/incr_arbiter.sv
// incr_arbiter: round-robin arbiter sharing one WIDTH-bit incrementer between
// NREQ requesters. The winner's operand+1 is registered with its index in a
// single-entry response register; a wrapping counter tallies accepted grants.
module incr_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 70,
   parameter  int CNTW  = 8,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset_l,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   input  logic                  rsp_ready,
   output logic [CNTW-1:0]       grant_count
);

   logic [WIDTH-1:0] op [NREQ];

   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [IDW-1:0]   ptr_q, ptr_d;

   logic             found, can_accept, grant;
   logic [IDW-1:0]   win_id;

   // (a + k) mod NREQ for k in 0..NREQ; works for non-power-of-two NREQ
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int k);
      int s;
      s = int'(a) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   // split the flat operand bus into one slice per requester
   for (genvar i = 0; i < NREQ; i++) begin : g_op
      assign op[i] = req_data[i*WIDTH +: WIDTH];
   end

   // search from ptr upward for the first valid requester; grant only if the
   // response register is free or being drained this cycle
   always_comb begin
      logic [IDW-1:0] idx;
      idx    = '0;
      found  = 1'b0;
      win_id = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = wrap_add(ptr_q, k);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
      can_accept = !rsp_valid_q || rsp_ready;
      grant      = found && can_accept;
      req_ready  = '0;
      if (grant) req_ready[win_id] = 1'b1;
   end

   // response register / pointer / counter next state; a grant in the same
   // cycle as a drain simply overwrites, so there is no bubble
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      if (grant) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = win_id;
         rsp_data_d  = op[win_id] + 1'b1;
         ptr_d       = wrap_add(win_id, 1);
         cnt_d       = cnt_q + 1'b1;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // state registers; reset discards any in-flight response
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign grant_count = cnt_q;

endmodule

// File: tb/tb_incr_arbiter.sv
// tb_incr_arbiter: directed stimulus with a response scoreboard. Expected
// responses are queued when a grant is issued; a negedge monitor pops and
// compares every response the consumer accepts.
module tb_incr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 70;
   localparam int CNTW  = 8;

   typedef struct {
      logic [1:0]       id;
      logic [WIDTH-1:0] data;
      logic [CNTW-1:0]  cnt;
   } exp_t;

   logic                  clk;
   logic                  reset_l;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_ready;
   logic [CNTW-1:0]       grant_count;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   incr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .clk(clk), .reset_l(reset_l),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ready(rsp_ready), .grant_count(grant_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [WIDTH-1:0] data, input int cnt);
      exp_t e;
      e.id   = 2'(id);
      e.data = data;
      e.cnt  = CNTW'(cnt);
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [WIDTH-1:0] v);
      req_data[i*WIDTH +: WIDTH] = v;
   endtask

   // monitor: every accepted response must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_l && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", {rsp_id, rsp_data}, '1);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id",      128'(rsp_id),      128'(e.id));
               chk("rsp_data",    128'(rsp_data),    128'(e.data));
               chk("grant_count", 128'(grant_count), 128'(e.cnt));
            end
         end
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_l   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      #1;
      chk("rst_valid", 128'(rsp_valid),   0);
      chk("rst_id",    128'(rsp_id),      0);
      chk("rst_data",  128'(rsp_data),    0);
      chk("rst_cnt",   128'(grant_count), 0);
      chk("rst_ready", 128'(req_ready),   0);
      step(); step();
      reset_l = 1'b1;

      // single requester 2, operand 5
      req_valid = 4'b0100;
      set_op(2, 70'd5);
      rsp_ready = 1'b1;
      #1;
      chk("single_ready", 128'(req_ready), 128'(4'b0100));
      push(2, 70'd6, 1);
      step();
      req_valid = '0;
      chk("single_valid", 128'(rsp_valid), 1);
      step(); step();

      // re-reset to put ptr back at 0
      reset_l = 1'b0;
      step();
      reset_l = 1'b1;

      // all valid: rotation 0,1,2,3,0
      set_op(0, 70'd10); set_op(1, 70'd20); set_op(2, 70'd30); set_op(3, 70'd40);
      req_valid = 4'b1111;
      #1;
      chk("rr_ready0", 128'(req_ready), 128'(4'b0001)); push(0, 70'd11, 1); step();
      chk("rr_ready1", 128'(req_ready), 128'(4'b0010)); push(1, 70'd21, 2); step();
      chk("rr_ready2", 128'(req_ready), 128'(4'b0100)); push(2, 70'd31, 3); step();
      chk("rr_ready3", 128'(req_ready), 128'(4'b1000)); push(3, 70'd41, 4); step();
      chk("rr_ready4", 128'(req_ready), 128'(4'b0001)); push(0, 70'd11, 5); step();
      req_valid = '0;
      step();

      // wrap-around operands; ptr is 1 so requester 1 goes first
      set_op(0, {WIDTH{1'b1}});
      set_op(1, 70'd0);
      req_valid = 4'b0011;
      #1;
      chk("wrap_ready1", 128'(req_ready), 128'(4'b0010)); push(1, 70'd1, 6); step();
      req_valid = 4'b0001;
      #1;
      chk("wrap_ready0", 128'(req_ready), 128'(4'b0001)); push(0, 70'd0, 7); step();
      req_valid = '0;
      step();

      // backpressure: one grant to requester 1, then hold for 5 cycles
      set_op(0, 70'd10); set_op(1, 70'd20);
      req_valid = 4'b1111;
      rsp_ready = 1'b0;
      push(1, 70'd21, 8);
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_ready", 128'(req_ready),   0);
         chk("bp_valid", 128'(rsp_valid),   1);
         chk("bp_id",    128'(rsp_id),      1);
         chk("bp_data",  128'(rsp_data),    21);
         chk("bp_cnt",   128'(grant_count), 8);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_resume_ready", 128'(req_ready), 128'(4'b0100));
      push(2, 70'd31, 9);
      step();
      req_valid = '0;
      step();

      // counter wrap: 248 more grants to requester 0 (count 9 -> 256 -> 257)
      req_valid = 4'b0001;
      for (int n = 1; n <= 248; n++) begin
         set_op(0, 70'(n));
         push(0, 70'(n + 1), (9 + n) % 256);
         step();
         if (n == 247) chk("cnt_wrap0", 128'(grant_count), 0);
      end
      chk("cnt_wrap1", 128'(grant_count), 1);

      // reset mid-operation with a response held
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
      chk("pre_rst_valid", 128'(rsp_valid), 1);
      void'(exp_q.pop_back());   // held response is discarded by reset
      #2;
      reset_l = 1'b0;
      #1;
      chk("mid_rst_valid", 128'(rsp_valid),   0);
      chk("mid_rst_data",  128'(rsp_data),    0);
      chk("mid_rst_cnt",   128'(grant_count), 0);
      step();
      reset_l = 1'b1;
      set_op(0, 70'd10);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready", 128'(req_ready), 128'(4'b0001));
      push(0, 70'd11, 1);
      step();
      req_valid = '0;
      step(); step();

      chk("scoreboard_empty", 128'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/incr_arbiter.md
# incr_arbiter

Round-robin arbiter that shares one WIDTH-bit incrementer between NREQ requesters. Each requester presents an operand with a valid/ready handshake. The arbiter grants one requester per cycle and registers operand+1 with the requester's index into a single-entry response register. It sits between the stimulus/requester logic and the shared wide-arithmetic datapath in the simulation top, and keeps a wrapping grant counter for run statistics.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 70, operand/result width in bits
- CNTW, 8, grant counter width
- clk  input  1  single clock; all state updates on posedge
- reset_l  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  bit i: requester i has an operand pending
- req_data  input  NREQ*WIDTH  operand of requester i in bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot (or zero) grant; combinational
- rsp_valid  output  1  response register holds a result
- rsp_id  output  $clog2(NREQ)  index of the requester that produced the result
- rsp_data  output  WIDTH  operand+1, modulo 2^WIDTH
- rsp_ready  input  1  consumer accepts the response this cycle
- grant_count  output  CNTW  total accepted requests, wraps modulo 2^CNTW

## Operation
- Reset (reset_l=0, asynchronous): rsp_valid=0, rsp_id=0, rsp_data=0, grant_count=0, priority pointer=0. Any in-flight response is discarded.
- can_accept = !rsp_valid || rsp_ready.
- Arbitration is combinational and searches from pointer ptr upward, wrapping modulo NREQ. The first i with req_valid[i]=1 is the winner.
- req_ready[winner]=1 only if can_accept; all other bits are 0. req_ready is all-zero when no req_valid is set or can_accept=0.
- Handshake for requester i: req_valid[i] && req_ready[i] on a posedge. On that edge:
  - rsp_data <= req_data[i] + 1, truncated to WIDTH bits (all-ones wraps to 0)
  - rsp_id <= i
  - rsp_valid <= 1
  - ptr <= (i+1) mod NREQ
  - grant_count <= grant_count+1, wrapping
- Drain: rsp_valid && rsp_ready with no new grant -> rsp_valid <= 0. rsp_data and rsp_id keep their last values.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and rsp_valid stays 1. No bubble.
- While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_data are held stable and no grant is issued. ptr does not move.
- Requesters must hold req_valid and req_data stable until granted. Dropping req_valid without a grant is allowed and simply removes the requester from arbitration.
- ptr changes only on a grant. The arbiter never grants a requester whose req_valid=0.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 grants.

## Timing
- Latency: grant at edge N -> rsp_valid=1 with the result visible after edge N, consumable at edge N+1.
- Throughput: one grant per cycle while rsp_ready=1.
- req_ready depends combinationally on req_valid, ptr, rsp_valid and rsp_ready. There is no combinational path from req_data to any output.
- Reset assertion takes effect immediately. Deassertion is synchronised externally; the first grant can occur on the first posedge after reset_l rises.

## Test plan
- Single requester: reset, then req_valid=4'b0100, req_data[2]=5, rsp_ready=1 -> req_ready=4'b0100 the same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=6, grant_count=1.
- All valid, rsp_ready=1, ptr=0: grants occur in order 0,1,2,3,0 over five cycles, with rsp_id following one cycle later. Operands 10,20,30,40 -> rsp_data 11,21,31,41.
- Wrap-around: req_data[0]=70'h3F_FFFF_FFFF_FFFF_FFFF -> rsp_data=0. req_data[1]=0 -> rsp_data=1.
- Backpressure: with rsp_valid=1 and rsp_ready=0 for 5 cycles under all-valid requests -> req_ready=0, and rsp_data/rsp_id/grant_count/ptr are unchanged. On raising rsp_ready, the next grant goes to the requester after the last one granted.
- Counter wrap: 256 grants with CNTW=8 -> grant_count returns to 0; the 257th grant gives 1.
- Reset mid-operation: assert reset_l=0 between edges while rsp_valid=1 -> rsp_valid, rsp_data and grant_count go to 0 immediately. After release, all requesters valid -> the first grant goes to requester 0.
